// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: fetches sequential words from the instruction
// ROM into a small FIFO of {pc, inst} pairs and presents the head to the core.
// A flush from the core redirects fetching and discards everything queued.
module inst_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_ce_o,
    output logic [31:0]              rom_addr_o,
    input  logic [31:0]              rom_data_i,
    input  logic                     flush_i,
    input  logic [31:0]              flush_pc_i,
    output logic                     inst_valid_o,
    input  logic                     inst_ready_i,
    output logic [31:0]              inst_o,
    output logic [31:0]              inst_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic            valid_s;
    logic            push_s;
    logic            pop_s;
    logic [31:0]     redirect_pc_s;

    // Head is only exposed while out of reset so nothing leaks during reset.
    assign valid_s       = rst && (count_q != {CW{1'b0}});
    // Redirect target forced to a word boundary.
    assign redirect_pc_s = flush_pc_i & 32'hFFFF_FFFC;

    // Next-state logic: FSM, fetch pointer, queue pointers and occupancy.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (flush_i) begin
                    fetch_pc_d = redirect_pc_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    fetch_pc_d = redirect_pc_s;
                    wr_ptr_d   = {PW{1'b0}};
                    rd_ptr_d   = {PW{1'b0}};
                    count_d    = {CW{1'b0}};
                end else begin
                    pop_s  = valid_s && inst_ready_i;
                    // A pop frees a slot this same cycle, so a full queue keeps streaming.
                    push_s = rst && ((count_q < DEPTH_C) || pop_s);
                    if (push_s) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        wr_ptr_d   = wr_ptr_q + PW'(1);
                    end else begin
                        fetch_pc_d = fetch_pc_q;
                    end
                    if (pop_s) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end else begin
                        rd_ptr_d = rd_ptr_q;
                    end
                    if (push_s && !pop_s) begin
                        count_d = count_q + CW'(1);
                    end else if (pop_s && !push_s) begin
                        count_d = count_q - CW'(1);
                    end else begin
                        count_d = count_q;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage: capture the fetched word and its address at the tail.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= rom_data_i;
        end
    end

    // Head presentation, zeroed when the queue is empty.
    always_comb begin
        inst_o    = 32'h0000_0000;
        inst_pc_o = 32'h0000_0000;
        if (valid_s) begin
            inst_o    = inst_mem_q[rd_ptr_q];
            inst_pc_o = pc_mem_q[rd_ptr_q];
        end else begin
            inst_o    = 32'h0000_0000;
            inst_pc_o = 32'h0000_0000;
        end
    end

    assign rom_ce_o     = push_s;
    assign rom_addr_o   = fetch_pc_q;
    assign inst_valid_o = valid_s;
    assign count_o      = count_q;

endmodule

// File: tb/tb_inst_prefetch.sv
// Testbench for inst_prefetch: directed scenarios plus a randomized stream
// compared against an in-order sequential-address model of the ROM.
module tb_inst_prefetch;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  count;

    logic        w_rom_ce;
    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_data;
    logic        w_inst_valid;
    logic        w_ready;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic [2:0]  w_count;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign rom_data   = rom_fn(rom_addr);
    assign w_rom_data = rom_fn(w_rom_addr);

    inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .flush_i(flush), .flush_pc_i(flush_pc),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_o(inst),
        .inst_pc_o(inst_pc), .count_o(count)
    );

    inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst), .rom_ce_o(w_rom_ce), .rom_addr_o(w_rom_addr),
        .rom_data_i(w_rom_data), .flush_i(1'b0), .flush_pc_i(32'h0000_0000),
        .inst_valid_o(w_inst_valid), .inst_ready_i(w_ready), .inst_o(w_inst),
        .inst_pc_o(w_inst_pc), .count_o(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; flush_pc = 32'h0; inst_ready = 1'b0; w_ready = 1'b0;
        @(posedge clk); step();
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %0b exp 0", rom_ce); end
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_head got v=%0b i=%h pc=%h exp 0", inst_valid, inst, inst_pc); end
        checks++; if (count !== 3'd0 || rom_addr !== 32'h0) begin errors++; $display("FAIL reset_state got cnt=%0d addr=%h exp 0/0", count, rom_addr); end
        rst = 1'b1; #1;
        checks++; if (rom_ce !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL boot_idle got ce=%0b v=%0b exp 0/0", rom_ce, inst_valid); end
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'(4*i) || count !== 3'(i)) begin errors++; $display("FAIL fill_%0d got ce=%0b addr=%h cnt=%0d exp 1/%h/%0d", i, rom_ce, rom_addr, count, 32'(4*i), i); end
            step();
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || count !== 3'(i+1)) begin errors++; $display("FAIL filled_%0d got v=%0b pc=%h cnt=%0d exp 1/0/%0d", i, inst_valid, inst_pc, count, i+1); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (rom_ce !== 1'b0 || count !== 3'd4 || inst_pc !== 32'h0 || inst !== rom_fn(32'h0)) begin errors++; $display("FAIL full_hold got ce=%0b cnt=%0d pc=%h i=%h exp 0/4/0/%h", rom_ce, count, inst_pc, inst, rom_fn(32'h0)); end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'hFFFF_FFF8 + 32'(4*i);
            #1;
            checks++; if (w_inst_pc !== pc || w_inst !== rom_fn(pc) || w_inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_%0d got pc=%h i=%h exp %h/%h", i, w_inst_pc, w_inst, pc, rom_fn(pc)); end
            step();
        end
        w_ready = 1'b0;
    endtask

    task automatic test_full_stream();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (inst_pc !== 32'(4*i) || inst !== rom_fn(32'(4*i)) || count !== 3'd4 || rom_ce !== 1'b1) begin errors++; $display("FAIL stream_%0d got pc=%h cnt=%0d ce=%0b exp %h/4/1", i, inst_pc, count, rom_ce, 32'(4*i)); end
            step();
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_flush();
        flush = 1'b1; flush_pc = 32'h0000_0200; #1;
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL flush_ce got %0b exp 0", rom_ce); end
        step(); flush = 1'b0; #1;
        checks++; if (count !== 3'd0 || rom_addr !== 32'h200 || inst_valid !== 1'b0) begin errors++; $display("FAIL flush_a got cnt=%0d addr=%h v=%0b exp 0/200/0", count, rom_addr, inst_valid); end
        repeat (3) step();
        checks++; if (count !== 3'd3 || inst_pc !== 32'h200) begin errors++; $display("FAIL refill got cnt=%0d pc=%h exp 3/200", count, inst_pc); end
        flush = 1'b1; flush_pc = 32'h0000_0103; inst_ready = 1'b1; #1;
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL flush_nopush got %0b exp 0", rom_ce); end
        step(); flush = 1'b0; inst_ready = 1'b0; #1;
        checks++; if (count !== 3'd0 || rom_addr !== 32'h100 || inst_valid !== 1'b0) begin errors++; $display("FAIL flush_b got cnt=%0d addr=%h v=%0b exp 0/100/0", count, rom_addr, inst_valid); end
        step();
        checks++; if (inst_pc !== 32'h100 || inst !== rom_fn(32'h100) || count !== 3'd1) begin errors++; $display("FAIL flush_lat got pc=%h cnt=%0d exp 100/1", inst_pc, count); end
    endtask

    task automatic test_random();
        logic [31:0] base, exp_pc, fetch_exp;
        int model_cnt;
        bit pop, push;
        base = $urandom() & 32'h00FF_FFFC;
        flush = 1'b1; flush_pc = base; inst_ready = 1'b0;
        step(); flush = 1'b0;
        model_cnt = 0; exp_pc = base; fetch_exp = base;
        for (int c = 0; c < 1000; c++) begin
            inst_ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if (count !== 3'(model_cnt) || inst_valid !== (model_cnt != 0) || rom_addr !== fetch_exp) begin errors++; $display("FAIL rnd_state_%0d got cnt=%0d v=%0b addr=%h exp %0d/%h", c, count, inst_valid, rom_addr, model_cnt, fetch_exp); end
            pop = (model_cnt > 0) && inst_ready;
            push = (model_cnt < DEPTH) || pop;
            if (pop) begin
                checks++; if (inst_pc !== exp_pc || inst !== rom_fn(exp_pc)) begin errors++; $display("FAIL rnd_data_%0d got pc=%h i=%h exp %h/%h", c, inst_pc, inst, exp_pc, rom_fn(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            checks++; if (rom_ce !== push) begin errors++; $display("FAIL rnd_ce_%0d got %0b exp %0b", c, rom_ce, push); end
            if (push) fetch_exp = fetch_exp + 32'd4;
            model_cnt = model_cnt + int'(push) - int'(pop);
            step();
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        flush = 1'b1; flush_pc = 32'h0000_0800; step(); flush = 1'b0;
        repeat (3) step();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_rst got cnt=%0d exp 3", count); end
        rst = 1'b0; flush = 1'b1; flush_pc = 32'h0000_0C00; #1;
        checks++; if (rom_ce !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL in_rst got ce=%0b v=%0b exp 0/0", rom_ce, inst_valid); end
        step(); flush = 1'b0; #1;
        checks++; if (count !== 3'd0 || inst_valid !== 1'b0 || rom_addr !== 32'h0) begin errors++; $display("FAIL mid_rst got cnt=%0d v=%0b addr=%h exp 0/0/0", count, inst_valid, rom_addr); end
        rst = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0406; #1;
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL boot_flush_ce got %0b exp 0", rom_ce); end
        step(); flush = 1'b0; #1;
        checks++; if (rom_addr !== 32'h404 || count !== 3'd0 || rom_ce !== 1'b1) begin errors++; $display("FAIL boot_flush got addr=%h cnt=%0d ce=%0b exp 404/0/1", rom_addr, count, rom_ce); end
        step();
        checks++; if (inst_pc !== 32'h404 || inst !== rom_fn(32'h404)) begin errors++; $display("FAIL boot_flush_head got pc=%h exp 404", inst_pc); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_full_stream();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameters, one per line:
- DEPTH, 4, prefetch queue entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports, one per line:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- rom_ce_o  out  1  instruction ROM chip enable; a fetch happens in every cycle it is high.
- rom_addr_o  out  32  byte address to ROM, always word-aligned.
- rom_data_i  in  32  ROM instruction word, valid in the same cycle as rom_addr_o.
- flush_i  in  1  redirect request from core (branch/jump).
- flush_pc_i  in  32  redirect target.
- inst_valid_o  out  1  queue head holds an instruction.
- inst_ready_i  in  1  core accepts the head this cycle.
- inst_o  out  32  head instruction word.
- inst_pc_o  out  32  address the head was fetched from.
- count_o  out  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-003 The block SHALL sit between the core fetch port and the instruction ROM, prefetching sequential words into a DEPTH-entry FIFO of {pc, inst} pairs.
REQ-004 FSM states SHALL be BOOT and RUN: reset -> BOOT; BOOT -> RUN unconditionally after one cycle; RUN persists until reset.
REQ-005 In BOOT, rom_ce_o SHALL be 0 and no push SHALL occur.
REQ-006 A pop SHALL occur when inst_valid_o and inst_ready_i are both 1 and flush_i is 0.
REQ-007 In RUN, rom_ce_o SHALL be 1 (combinationally) iff flush_i is 0 and (count_o < DEPTH or a pop occurs this cycle).
REQ-008 rom_addr_o SHALL equal the fetch_pc register at all times.
REQ-009 When rom_ce_o is 1, {fetch_pc, rom_data_i} SHALL be written to the tail at the clock edge, and fetch_pc SHALL advance by 4.
REQ-010 fetch_pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no error indication.
REQ-011 Simultaneous push and pop SHALL leave count_o unchanged, including at count_o = DEPTH.
REQ-012 inst_valid_o SHALL be 1 iff count_o > 0; inst_o/inst_pc_o SHALL show the head entry and SHALL be 0 when empty.
REQ-013 Head outputs SHALL hold stable while inst_valid_o = 1 and inst_ready_i = 0.
REQ-014 flush_i = 1 in RUN SHALL empty the queue at the next edge, suppress push and pop that cycle, and load fetch_pc with {flush_pc_i[31:2], 2'b00}.
REQ-015 flush_i in BOOT SHALL load fetch_pc as in REQ-014; the state SHALL still advance to RUN.
REQ-016 Fetch latency SHALL be one cycle: a word fetched at edge N SHALL be visible on inst_o after edge N when the queue was empty.
REQ-017 Pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-018 While rst = 0 at a rising edge: state <= BOOT, fetch_pc <= RESET_PC, read/write pointers <= 0, count_o <= 0.
REQ-019 During reset and the following BOOT cycle: rom_ce_o = 0, inst_valid_o = 0, inst_o = 0, inst_pc_o = 0.
REQ-020 Reset asserted mid-operation SHALL discard all queued entries and pending flush, taking effect at that edge.

Verification
REQ-021 Bench SHALL cover the following scenarios:
- Release reset, inst_ready_i = 0 -> BOOT one cycle; then 4 pushes at pcs 0, 4, 8, 0xC; count_o = 4, rom_ce_o = 0 thereafter.
- Full queue, inst_ready_i = 1 continuously -> one pop plus one push per cycle; inst_pc_o sequence 0, 4, 8, ... with no bubbles; count_o stays 4.
- flush_i = 1 with flush_pc_i = 0x0000_0103, queue holding 3 entries -> next cycle count_o = 0, rom_addr_o = 0x100; one cycle later inst_pc_o = 0x100.
- RESET_PC = 0xFFFF_FFF8 -> fetched pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- Random inst_ready_i, 1000 cycles -> delivered {pc, inst} stream equals the ROM model in order, with no loss or duplication.
- rst = 0 asserted with count_o = 3 -> next cycle count_o = 0, inst_valid_o = 0, rom_addr_o = RESET_PC.
